dot_matrix_ctrl_sequencer: RTL and testbench



---
 rtl/dm_ctrl_pkg.sv | 40 ++++
 rtl/btn_debounce.sv | 49 ++++
 rtl/dot_matrix_ctrl_sequencer.sv | 129 ++++++++++++
 tb/tb_dot_matrix_ctrl_sequencer.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/dm_ctrl_pkg.sv
// Shared state encoding, icon codes and counter sizing for the dot-matrix control sequencer.
// The CTRL_* values are the agreed code set read by the dot-matrix driver.
package dm_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_L1,
      ST_L2,
      ST_R1,
      ST_R2,
      ST_STOP
   } state_e;

   localparam logic [3:0] CTRL_IDLE = 4'b0000;
   localparam logic [3:0] CTRL_STOP = 4'b1111;
   localparam logic [3:0] CTRL_R1   = 4'b0001;
   localparam logic [3:0] CTRL_R2   = 4'b0011;
   localparam logic [3:0] CTRL_L1   = 4'b0100;
   localparam logic [3:0] CTRL_L2   = 4'b0110;

   function automatic logic [3:0] ctrl_code(input state_e s);
      logic [3:0] code;
      code = CTRL_IDLE;
      case (s)
         ST_L1:   code = CTRL_L1;
         ST_L2:   code = CTRL_L2;
         ST_R1:   code = CTRL_R1;
         ST_R2:   code = CTRL_R2;
         ST_STOP: code = CTRL_STOP;
         default: code = CTRL_IDLE;
      endcase
      return code;
   endfunction

   // Width of a counter that must hold values 0 .. n-1, never less than one bit.
   function automatic int cnt_width(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchronizer followed by a consecutive-sample debouncer for one raw button.
module btn_debounce
   import dm_ctrl_pkg::*;
#(
   parameter int DEB_CYCLES = 200
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic btn_i,
   output logic level_o
);

   localparam int CW = cnt_width(DEB_CYCLES);
   localparam logic [CW-1:0] CNT_LIM = CW'(DEB_CYCLES - 1);

   logic          sync1_q, sync2_q;
   logic          level_q, level_d;
   logic [CW-1:0] cnt_q, cnt_d;

   // Counter only advances while the synced value disagrees with the held level.
   always_comb begin
      level_d = level_q;
      cnt_d   = '0;
      if (sync2_q != level_q) begin
         if (cnt_q == CNT_LIM) begin
            level_d = sync2_q;
         end else begin
            cnt_d = cnt_q + CW'(1);
         end
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         level_q <= 1'b0;
         cnt_q   <= '0;
      end else begin
         sync1_q <= btn_i;
         sync2_q <= sync1_q;
         level_q <= level_d;
         cnt_q   <= cnt_d;
      end
   end

   assign level_o = level_q;

endmodule

// File: rtl/dot_matrix_ctrl_sequencer.sv
// Debounced left/right/stop buttons drive a direction/speed FSM that selects the
// dot-matrix icon code and paces move strobes for the game logic.
module dot_matrix_ctrl_sequencer
   import dm_ctrl_pkg::*;
#(
   parameter int DEB_CYCLES  = 200,
   parameter int HOLD_CYCLES = 5000,
   parameter int SLOW_PERIOD = 2000,
   parameter int FAST_PERIOD = 1000
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       btn_left,
   input  logic       btn_right,
   input  logic       btn_stop,
   output logic [3:0] control,
   output logic       move_pulse,
   output logic       move_dir,
   output logic       stopped
);

   localparam int HW = cnt_width(HOLD_CYCLES);
   localparam int PW = cnt_width(SLOW_PERIOD);
   localparam logic [HW-1:0] HOLD_LIM = HW'(HOLD_CYCLES - 1);
   localparam logic [PW-1:0] SLOW_LIM = PW'(SLOW_PERIOD - 1);
   localparam logic [PW-1:0] FAST_LIM = PW'(FAST_PERIOD - 1);

   logic lvl_l, lvl_r, lvl_s;

   btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_left  (.clk_i(clock), .rst_i(reset), .btn_i(btn_left),  .level_o(lvl_l));
   btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_right (.clk_i(clock), .rst_i(reset), .btn_i(btn_right), .level_o(lvl_r));
   btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_stop  (.clk_i(clock), .rst_i(reset), .btn_i(btn_stop),  .level_o(lvl_s));

   state_e        state_q, state_d;
   logic [3:0]    control_q, control_d;
   logic          stopped_q, stopped_d;
   logic          pulse_q, pulse_d;
   logic          dir_q, dir_d;
   logic          stop_prev_q;
   logic [HW-1:0] hold_cnt_q, hold_cnt_d;
   logic [PW-1:0] per_cnt_q, per_cnt_d;
   logic          stop_evt, moving, changing;
   logic [PW-1:0] per_lim;

   assign stop_evt = lvl_s & ~stop_prev_q;

   always_comb begin
      state_d = state_q;
      if (stop_evt) begin
         state_d = (state_q == ST_STOP) ? ST_IDLE : ST_STOP;
      end else if (state_q == ST_STOP) begin
         state_d = ST_STOP;
      end else if (lvl_l && lvl_r) begin
         state_d = ST_IDLE;
      end else if (lvl_l) begin
         case (state_q)
            ST_L1:   state_d = (hold_cnt_q == HOLD_LIM) ? ST_L2 : ST_L1;
            ST_L2:   state_d = ST_L2;
            default: state_d = ST_L1;
         endcase
      end else if (lvl_r) begin
         case (state_q)
            ST_R1:   state_d = (hold_cnt_q == HOLD_LIM) ? ST_R2 : ST_R1;
            ST_R2:   state_d = ST_R2;
            default: state_d = ST_R1;
         endcase
      end else begin
         state_d = ST_IDLE;
      end
   end

   // A pulse is suppressed on a state-change edge so it can never land in IDLE/STOP.
   always_comb begin
      changing   = (state_d != state_q);
      moving     = (state_q == ST_L1) || (state_q == ST_L2) || (state_q == ST_R1) || (state_q == ST_R2);
      per_lim    = ((state_q == ST_L2) || (state_q == ST_R2)) ? FAST_LIM : SLOW_LIM;
      hold_cnt_d = hold_cnt_q;
      per_cnt_d  = '0;
      pulse_d    = 1'b0;
      dir_d      = dir_q;
      if (changing) begin
         hold_cnt_d = '0;
      end else if (((state_q == ST_L1) || (state_q == ST_R1)) && (hold_cnt_q != HOLD_LIM)) begin
         hold_cnt_d = hold_cnt_q + HW'(1);
      end
      if (!changing && moving) begin
         if (per_cnt_q == per_lim) begin
            pulse_d = 1'b1;
         end else begin
            per_cnt_d = per_cnt_q + PW'(1);
         end
      end
      case (state_d)
         ST_L1, ST_L2: dir_d = 1'b0;
         ST_R1, ST_R2: dir_d = 1'b1;
         default:      dir_d = dir_q;
      endcase
      control_d = ctrl_code(state_d);
      stopped_d = (state_d == ST_STOP);
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         control_q   <= CTRL_IDLE;
         stopped_q   <= 1'b0;
         pulse_q     <= 1'b0;
         dir_q       <= 1'b0;
         stop_prev_q <= 1'b0;
         hold_cnt_q  <= '0;
         per_cnt_q   <= '0;
      end else begin
         state_q     <= state_d;
         control_q   <= control_d;
         stopped_q   <= stopped_d;
         pulse_q     <= pulse_d;
         dir_q       <= dir_d;
         stop_prev_q <= lvl_s;
         hold_cnt_q  <= hold_cnt_d;
         per_cnt_q   <= per_cnt_d;
      end
   end

   assign control    = control_q;
   assign stopped    = stopped_q;
   assign move_pulse = pulse_q;
   assign move_dir   = dir_q;

endmodule

// File: tb/tb_dot_matrix_ctrl_sequencer.sv
// Directed-vector bench for the dot-matrix control sequencer with short debounce/hold/period settings.
module tb_dot_matrix_ctrl_sequencer;

   logic       clock, reset, btn_left, btn_right, btn_stop;
   logic [3:0] control;
   logic       move_pulse, move_dir, stopped;

   int n_vec = 0;
   int n_err = 0;

   dot_matrix_ctrl_sequencer #(
      .DEB_CYCLES(4), .HOLD_CYCLES(20), .SLOW_PERIOD(8), .FAST_PERIOD(4)
   ) dut (
      .clock(clock), .reset(reset), .btn_left(btn_left), .btn_right(btn_right),
      .btn_stop(btn_stop), .control(control), .move_pulse(move_pulse),
      .move_dir(move_dir), .stopped(stopped)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic cyc(input int n);
      repeat (n) @(negedge clock);
   endtask

   task automatic do_reset();
      @(negedge clock);
      reset = 1'b1;
      btn_left = 1'b0; btn_right = 1'b0; btn_stop = 1'b0;
      cyc(3);
      reset = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1; btn_left = 1'b1; btn_right = 1'b0; btn_stop = 1'b1;
      cyc(10);
      n_vec++; if (control !== 4'b0000) begin n_err++; $display("FAIL reset_ctrl got %b exp 0000", control); end
      n_vec++; if (move_pulse !== 1'b0) begin n_err++; $display("FAIL reset_pulse got %b exp 0", move_pulse); end
      n_vec++; if (move_dir !== 1'b0) begin n_err++; $display("FAIL reset_dir got %b exp 0", move_dir); end
      n_vec++; if (stopped !== 1'b0) begin n_err++; $display("FAIL reset_stopped got %b exp 0", stopped); end
   endtask

   task automatic test_left_hold();
      logic [3:0] ec; logic ep;
      do_reset();
      btn_left = 1'b1;
      for (int k = 1; k <= 40; k++) begin
         cyc(1);
         ec = (k < 7) ? 4'b0000 : (k < 27) ? 4'b0100 : 4'b0110;
         ep = (k == 15 || k == 23 || k == 31 || k == 35 || k == 39);
         n_vec++; if (control !== ec) begin n_err++; $display("FAIL left_ctrl k=%0d got %b exp %b", k, control, ec); end
         n_vec++; if (move_pulse !== ep) begin n_err++; $display("FAIL left_pulse k=%0d got %b exp %b", k, move_pulse, ep); end
         if (ep) begin
            n_vec++; if (move_dir !== 1'b0) begin n_err++; $display("FAIL left_dir k=%0d got %b exp 0", k, move_dir); end
         end
      end
   endtask

   task automatic test_glitch();
      do_reset();
      btn_right = 1'b1;
      cyc(3);
      btn_right = 1'b0;
      for (int k = 1; k <= 20; k++) begin
         cyc(1);
         n_vec++; if (control !== 4'b0000) begin n_err++; $display("FAIL glitch_ctrl k=%0d got %b exp 0000", k, control); end
         n_vec++; if (move_pulse !== 1'b0) begin n_err++; $display("FAIL glitch_pulse k=%0d got %b exp 0", k, move_pulse); end
      end
   endtask

   task automatic test_both_cancel();
      logic [3:0] ec;
      do_reset();
      btn_left = 1'b1; btn_right = 1'b1;
      for (int k = 1; k <= 20; k++) begin
         cyc(1);
         n_vec++; if (control !== 4'b0000) begin n_err++; $display("FAIL both_ctrl k=%0d got %b exp 0000", k, control); end
         n_vec++; if (move_pulse !== 1'b0) begin n_err++; $display("FAIL both_pulse k=%0d got %b exp 0", k, move_pulse); end
      end
      btn_right = 1'b0;
      for (int k = 1; k <= 10; k++) begin
         cyc(1);
         ec = (k < 7) ? 4'b0000 : 4'b0100;
         n_vec++; if (control !== ec) begin n_err++; $display("FAIL both_release k=%0d got %b exp %b", k, control, ec); end
      end
   endtask

   task automatic test_stop();
      logic [3:0] ec; logic es;
      do_reset();
      btn_right = 1'b1;
      cyc(30);
      n_vec++; if (control !== 4'b0011) begin n_err++; $display("FAIL stop_pre_r2 got %b exp 0011", control); end
      btn_stop = 1'b1;
      for (int k = 1; k <= 10; k++) begin
         cyc(1);
         ec = (k < 7) ? 4'b0011 : 4'b1111;
         es = (k >= 7);
         n_vec++; if (control !== ec) begin n_err++; $display("FAIL stop_enter_ctrl k=%0d got %b exp %b", k, control, ec); end
         n_vec++; if (stopped !== es) begin n_err++; $display("FAIL stop_enter_stopped k=%0d got %b exp %b", k, stopped, es); end
         if (k >= 7) begin
            n_vec++; if (move_pulse !== 1'b0) begin n_err++; $display("FAIL stop_enter_pulse k=%0d got %b exp 0", k, move_pulse); end
         end
      end
      n_vec++; if (move_dir !== 1'b1) begin n_err++; $display("FAIL stop_dir_hold got %b exp 1", move_dir); end
      btn_stop = 1'b0; btn_right = 1'b0; btn_left = 1'b1;
      for (int k = 1; k <= 25; k++) begin
         cyc(1);
         n_vec++; if (control !== 4'b1111) begin n_err++; $display("FAIL stop_hold_ctrl k=%0d got %b exp 1111", k, control); end
         n_vec++; if (move_pulse !== 1'b0) begin n_err++; $display("FAIL stop_hold_pulse k=%0d got %b exp 0", k, move_pulse); end
      end
      btn_stop = 1'b1;
      for (int k = 1; k <= 9; k++) begin
         cyc(1);
         ec = (k < 7) ? 4'b1111 : (k == 7) ? 4'b0000 : 4'b0100;
         es = (k < 7);
         n_vec++; if (control !== ec) begin n_err++; $display("FAIL stop_exit_ctrl k=%0d got %b exp %b", k, control, ec); end
         n_vec++; if (stopped !== es) begin n_err++; $display("FAIL stop_exit_stopped k=%0d got %b exp %b", k, stopped, es); end
      end
      btn_stop = 1'b0;
   endtask

   task automatic test_reversal();
      logic [3:0] ec; logic ep, ed;
      do_reset();
      btn_left = 1'b1;
      cyc(30);
      n_vec++; if (control !== 4'b0110) begin n_err++; $display("FAIL rev_pre_l2 got %b exp 0110", control); end
      btn_left = 1'b0;
      for (int k = 1; k <= 32; k++) begin
         cyc(1);
         ec = (k < 7) ? 4'b0110 : (k < 10) ? 4'b0000 : (k < 30) ? 4'b0001 : 4'b0011;
         ep = (k == 1 || k == 5 || k == 18 || k == 26);
         ed = (k >= 10);
         n_vec++; if (control !== ec) begin n_err++; $display("FAIL rev_ctrl k=%0d got %b exp %b", k, control, ec); end
         n_vec++; if (move_pulse !== ep) begin n_err++; $display("FAIL rev_pulse k=%0d got %b exp %b", k, move_pulse, ep); end
         if (ep) begin
            n_vec++; if (move_dir !== ed) begin n_err++; $display("FAIL rev_dir k=%0d got %b exp %b", k, move_dir, ed); end
         end
         if (k == 3) btn_right = 1'b1;
      end
   endtask

   task automatic test_async_reset();
      logic [3:0] ec;
      do_reset();
      btn_right = 1'b1;
      cyc(31);
      n_vec++; if (control !== 4'b0011) begin n_err++; $display("FAIL arst_pre_ctrl got %b exp 0011", control); end
      n_vec++; if (move_pulse !== 1'b1) begin n_err++; $display("FAIL arst_pre_pulse got %b exp 1", move_pulse); end
      #2 reset = 1'b1;
      #1;
      n_vec++; if (control !== 4'b0000) begin n_err++; $display("FAIL arst_ctrl got %b exp 0000", control); end
      n_vec++; if (move_pulse !== 1'b0) begin n_err++; $display("FAIL arst_pulse got %b exp 0", move_pulse); end
      n_vec++; if (stopped !== 1'b0) begin n_err++; $display("FAIL arst_stopped got %b exp 0", stopped); end
      n_vec++; if (move_dir !== 1'b0) begin n_err++; $display("FAIL arst_dir got %b exp 0", move_dir); end
      @(negedge clock);
      reset = 1'b0;
      for (int k = 1; k <= 8; k++) begin
         cyc(1);
         ec = (k < 7) ? 4'b0000 : 4'b0001;
         n_vec++; if (control !== ec) begin n_err++; $display("FAIL arst_reentry k=%0d got %b exp %b", k, control, ec); end
      end
   endtask

   initial begin
      reset = 1'b1; btn_left = 1'b0; btn_right = 1'b0; btn_stop = 1'b0;
      test_reset();
      test_left_hold();
      test_glitch();
      test_both_cancel();
      test_stop();
      test_reversal();
      test_async_reset();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
